// File: rtl/perm_matcher_seq.sv
// Sequential permutation matcher: maps each A lane to an equal, unused B lane, one lane per clock.
// Optional build macro PERM_MATCHER_PREFER_IDENTITY_EN keeps a lane in place when B[i] already matches A[i].
module perm_matcher_seq #(
  parameter  int N    = 4,
  parameter  int W    = 2,
  localparam int IDXW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*W-1:0]    a_vec,
  input  logic [N*W-1:0]    b_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*IDXW-1:0] map_vec,
  output logic              match_ok,
  output logic [N-1:0]      unmatched_mask,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MATCH,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [N*W-1:0]    r_a;
  logic [N*W-1:0]    r_b;
  logic [N-1:0]      r_used;
  logic [N*IDXW-1:0] r_map;
  logic [N-1:0]      r_mask;
  logic              r_ok;
  logic [IDXW-1:0]   r_idx;

  logic [W-1:0]      w_aLane;
  logic              w_found;
  logic [IDXW-1:0]   w_sel;
  logic              w_lastLane;
  logic [N-1:0]      w_maskNext;
`ifdef PERM_MATCHER_PREFER_IDENTITY_EN
  logic [W-1:0]      w_bSelf;
  logic              w_usedSelf;
`endif

  // Candidate search for the current lane; the descending scan leaves the lowest free match selected.
  always_comb begin
    w_aLane    = '0;
    w_found    = 1'b0;
    w_sel      = '0;
    w_lastLane = (r_idx == IDXW'(N-1));
    w_maskNext = r_mask;
`ifdef PERM_MATCHER_PREFER_IDENTITY_EN
    w_bSelf    = '0;
    w_usedSelf = 1'b0;
`endif
    for (int k = 0; k < N; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_aLane = r_a[k*W +: W];
`ifdef PERM_MATCHER_PREFER_IDENTITY_EN
        w_bSelf    = r_b[k*W +: W];
        w_usedSelf = r_used[k];
`endif
      end
    end
    for (int j = N-1; j >= 0; j--) begin
      if ((r_b[j*W +: W] == w_aLane) && !r_used[j]) begin
        w_found = 1'b1;
        w_sel   = IDXW'(j);
      end
    end
`ifdef PERM_MATCHER_PREFER_IDENTITY_EN
    if ((w_bSelf == w_aLane) && !w_usedSelf) begin
      w_found = 1'b1;
      w_sel   = r_idx;
    end
`endif
    if (!w_found) begin
      for (int k = 0; k < N; k++) begin
        if (r_idx == IDXW'(k)) w_maskNext[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)   w_stateNext = S_MATCH;
      S_MATCH: if (w_lastLane) w_stateNext = S_DONE;
      S_DONE:  if (out_ready)  w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Job datapath; results are only touched on accept and during MATCH, so they hold through DONE and after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_used <= '0;
      r_map  <= '0;
      r_mask <= '0;
      r_ok   <= 1'b0;
      r_idx  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a    <= a_vec;
            r_b    <= b_vec;
            r_used <= '0;
            r_map  <= '0;
            r_mask <= '0;
            r_ok   <= 1'b0;
            r_idx  <= '0;
          end
        end
        S_MATCH: begin
          r_mask <= w_maskNext;
          for (int j = 0; j < N; j++) begin
            if (w_found && (w_sel == IDXW'(j))) r_used[j] <= 1'b1;
          end
          for (int k = 0; k < N; k++) begin
            if (r_idx == IDXW'(k)) r_map[k*IDXW +: IDXW] <= w_found ? w_sel : '0;
          end
          if (w_lastLane) r_ok  <= ~|w_maskNext;
          else            r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready       = (r_state == S_IDLE);
  assign out_valid      = (r_state == S_DONE);
  assign busy           = (r_state != S_IDLE);
  assign map_vec        = r_map;
  assign match_ok       = r_ok;
  assign unmatched_mask = r_mask;

endmodule

// File: tb/tb_perm_matcher_seq.sv
// Directed testbench for perm_matcher_seq (N=4, W=2); expectations are hand-computed per vector.
module tb_perm_matcher_seq;

  localparam int N    = 4;
  localparam int W    = 2;
  localparam int IDXW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [N*W-1:0]    a_vec;
  logic [N*W-1:0]    b_vec;
  logic              out_valid;
  logic              out_ready;
  logic [N*IDXW-1:0] map_vec;
  logic              match_ok;
  logic [N-1:0]      unmatched_mask;
  logic              busy;

  int checks = 0;
  int errors = 0;

  perm_matcher_seq #(.N(N), .W(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .a_vec          (a_vec),
    .b_vec          (b_vec),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .map_vec        (map_vec),
    .match_ok       (match_ok),
    .unmatched_mask (unmatched_mask),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Lane 0 sits in the least significant bits.
  function automatic logic [7:0] pack4(input int c0, input int c1, input int c2, input int c3);
    logic [1:0] l0, l1, l2, l3;
    l0 = 2'(c0);
    l1 = 2'(c1);
    l2 = 2'(c2);
    l3 = 2'(c3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic do_job(input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    a_vec    = a;
    b_vec    = b;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && lat < 30) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (map_vec !== 8'h00) begin errors++; $display("[TB] FAIL reset_map got %h want 00", map_vec); end
    checks++; if (match_ok !== 1'b0) begin errors++; $display("[TB] FAIL reset_match_ok got %b want 0", match_ok); end
    checks++; if (unmatched_mask !== 4'b0000) begin errors++; $display("[TB] FAIL reset_mask got %b want 0000", unmatched_mask); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_reverse();
    int lat;
    do_job(pack4(0,1,2,3), pack4(3,2,1,0), lat);
    checks++; if (lat != 4) begin errors++; $display("[TB] FAIL reverse_latency got %0d want 4", lat); end
    checks++; if (map_vec !== pack4(3,2,1,0)) begin errors++; $display("[TB] FAIL reverse_map got %h want %h", map_vec, pack4(3,2,1,0)); end
    checks++; if (match_ok !== 1'b1) begin errors++; $display("[TB] FAIL reverse_match_ok got %b want 1", match_ok); end
    checks++; if (unmatched_mask !== 4'b0000) begin errors++; $display("[TB] FAIL reverse_mask got %b want 0000", unmatched_mask); end
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reverse_done_flags got busy=%b in_ready=%b want 1/0", busy, in_ready); end
    release_out();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reverse_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    checks++; if (map_vec !== pack4(3,2,1,0) || match_ok !== 1'b1) begin errors++; $display("[TB] FAIL reverse_hold_after got map=%h ok=%b want %h/1", map_vec, match_ok, pack4(3,2,1,0)); end
  endtask

  task automatic test_duplicates();
    int lat;
    do_job(pack4(1,1,0,0), pack4(0,1,0,1), lat);
    checks++; if (lat != 4) begin errors++; $display("[TB] FAIL dup_latency got %0d want 4", lat); end
    checks++; if (map_vec !== pack4(1,3,0,2)) begin errors++; $display("[TB] FAIL dup_map got %h want %h", map_vec, pack4(1,3,0,2)); end
    checks++; if (match_ok !== 1'b1 || unmatched_mask !== 4'b0000) begin errors++; $display("[TB] FAIL dup_status got ok=%b mask=%b want 1/0000", match_ok, unmatched_mask); end
    release_out();
  endtask

  task automatic test_unmatched();
    int lat;
    do_job(pack4(2,2,2,2), pack4(2,0,2,1), lat);
    checks++; if (map_vec !== pack4(0,2,0,0)) begin errors++; $display("[TB] FAIL unmatched_map got %h want %h", map_vec, pack4(0,2,0,0)); end
    checks++; if (match_ok !== 1'b0) begin errors++; $display("[TB] FAIL unmatched_match_ok got %b want 0", match_ok); end
    checks++; if (unmatched_mask !== 4'b1100) begin errors++; $display("[TB] FAIL unmatched_mask got %b want 1100", unmatched_mask); end
    release_out();
  endtask

  task automatic test_back_to_back();
    int lat;
    int wait_cnt;
    do_job(pack4(0,1,2,3), pack4(3,2,1,0), lat);
    for (int c = 0; c < 5; c++) begin
      in_valid  = 1'b1;
      a_vec     = pack4(1,1,0,0);
      b_vec     = pack4(0,1,0,1);
      out_ready = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_flags cycle %0d got out_valid=%b in_ready=%b want 1/0", c, out_valid, in_ready); end
      checks++; if (map_vec !== pack4(3,2,1,0) || match_ok !== 1'b1 || unmatched_mask !== 4'b0000) begin errors++; $display("[TB] FAIL bp_hold cycle %0d got map=%h ok=%b mask=%b want %h/1/0000", c, map_vec, match_ok, unmatched_mask, pack4(3,2,1,0)); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    checks++; if (map_vec !== pack4(3,2,1,0)) begin errors++; $display("[TB] FAIL bp_release_map got %h want %h", map_vec, pack4(3,2,1,0)); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_next_accept got busy=%b in_ready=%b want 1/0", busy, in_ready); end
    wait_cnt = 0;
    while (out_valid !== 1'b1 && wait_cnt < 30) begin
      @(posedge clk);
      wait_cnt++;
      @(negedge clk);
    end
    checks++; if (wait_cnt != 4) begin errors++; $display("[TB] FAIL bp_next_latency got %0d want 4", wait_cnt); end
    checks++; if (map_vec !== pack4(1,3,0,2)) begin errors++; $display("[TB] FAIL bp_next_map got %h want %h", map_vec, pack4(1,3,0,2)); end
    release_out();
  endtask

  task automatic test_reset_mid_match();
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    a_vec    = pack4(0,1,2,3);
    b_vec    = pack4(3,2,1,0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1 || map_vec !== 8'h0b) begin errors++; $display("[TB] FAIL midrst_pre got busy=%b map=%h want 1/0b", busy, map_vec); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_flags got busy=%b out_valid=%b want 0/0", busy, out_valid); end
    checks++; if (map_vec !== 8'h00 || match_ok !== 1'b0 || unmatched_mask !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_outputs got map=%h ok=%b mask=%b want 00/0/0000", map_vec, match_ok, unmatched_mask); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready got %b want 1", in_ready); end
    do_job(pack4(2,2,2,2), pack4(2,0,2,1), lat);
    checks++; if (lat != 4) begin errors++; $display("[TB] FAIL midrst_fresh_latency got %0d want 4", lat); end
    checks++; if (map_vec !== pack4(0,2,0,0) || unmatched_mask !== 4'b1100 || match_ok !== 1'b0) begin errors++; $display("[TB] FAIL midrst_fresh got map=%h mask=%b ok=%b want %h/1100/0", map_vec, unmatched_mask, match_ok, pack4(0,2,0,0)); end
    release_out();
  endtask

  task automatic test_identity();
    int lat;
    logic [7:0] expMap;
`ifdef PERM_MATCHER_PREFER_IDENTITY_EN
    expMap = pack4(2,1,0,3);
`else
    expMap = pack4(2,0,1,3);
`endif
    do_job(pack4(2,1,1,0), pack4(1,1,2,0), lat);
    checks++; if (lat != 4) begin errors++; $display("[TB] FAIL identity_latency got %0d want 4", lat); end
    checks++; if (map_vec !== expMap) begin errors++; $display("[TB] FAIL identity_map got %h want %h", map_vec, expMap); end
    checks++; if (match_ok !== 1'b1 || unmatched_mask !== 4'b0000) begin errors++; $display("[TB] FAIL identity_status got ok=%b mask=%b want 1/0000", match_ok, unmatched_mask); end
    release_out();
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_vec     = '0;
    b_vec     = '0;
    test_reset();
    test_reverse();
    test_duplicates();
    test_unmatched();
    test_back_to_back();
    test_reset_mid_match();
    test_identity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
